neck_signal_shaper: RTL and testbench

//  Output conditioner downstream of the neck judge; drives the welder interface.

---
 rtl/neck_signal_shaper.sv | 145 ++++++++++++++
 tb/tb_neck_signal_shaper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/neck_signal_shaper.sv
// Qualifies the raw necking flag on ADC strobes and emits one fixed-width pulse per confirmed event.
// Latency: neck_out rises 1 clk after the confirming strobe; all outputs are registered.
// No backpressure: strobe-driven input, free-running output; en_shaper low aborts to IDLE.
module neck_signal_shaper #(
    parameter int CONFIRM_N      = 3,
    parameter int PULSE_CYCLES   = 2000,
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_shaper,
    input  logic             sample_valid,
    input  logic             neck_raw,
    output logic             neck_out,
    output logic             neck_busy,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int MAX_WIN = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CYC_W   = $clog2(MAX_WIN + 1);
    localparam int CONF_W  = $clog2(CONFIRM_N + 1);

    // Terminal counts: a window of N cycles runs its counter 0..N-1.
    localparam logic [CYC_W-1:0]  PULSE_LAST = CYC_W'(PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0]  HOLD_LAST  = CYC_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_LAST  = CONF_W'(CONFIRM_N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM,
        S_PULSE,
        S_HOLDOFF,
        S_REARM
    } state_t;

    state_t            state_q, state_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q;
    logic              busy_q;
    logic              enter_pulse;

    // Next-state logic: strobe qualification, pulse/hold-off timing, event counting.
    always_comb begin
        state_d     = state_q;
        conf_d      = conf_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        enter_pulse = 1'b0;

        if (!en_shaper) begin
            // Abort: drop everything except the diagnostic event count.
            state_d = S_IDLE;
            conf_d  = '0;
            cyc_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sample_valid && neck_raw) begin
                        if (CONFIRM_N == 1) begin
                            enter_pulse = 1'b1;
                        end else begin
                            conf_d  = CONF_W'(1);
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (sample_valid) begin
                        if (!neck_raw) begin
                            conf_d  = '0;
                            state_d = S_IDLE;
                        end else if (conf_q == CONF_LAST) begin
                            enter_pulse = 1'b1;
                        end else begin
                            conf_d = conf_q + CONF_W'(1);
                        end
                    end
                end
                S_PULSE: begin
                    if (cyc_q == PULSE_LAST) begin
                        cyc_d   = '0;
                        state_d = S_HOLDOFF;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    // Raw flag and strobes are deliberately blind here.
                    if (cyc_q == HOLD_LAST) begin
                        cyc_d   = '0;
                        state_d = S_REARM;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                S_REARM: begin
                    // Only a sampled low re-arms, so a stuck-high flag fires once.
                    if (sample_valid && !neck_raw) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    conf_d  = '0;
                    cyc_d   = '0;
                end
            endcase

            if (enter_pulse) begin
                state_d = S_PULSE;
                conf_d  = '0;
                cyc_d   = '0;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; outputs are decoded from next state so they align with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            conf_q  <= '0;
            cyc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            conf_q  <= conf_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            out_q   <= (state_d == S_PULSE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign neck_out  = out_q;
    assign neck_busy = busy_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_neck_signal_shaper.sv
// Bench for neck_signal_shaper: table of strobe-level vectors, hand-written timing sequences,
// then randomized stimulus against a timestamp-based reference model.
// Two instances share stimulus: a 16-bit counter and a 2-bit counter for saturation.
module tb_neck_signal_shaper;

    localparam int CONFIRM_N = 3;
    localparam int PULSE_C   = 10;
    localparam int HOLD_C    = 20;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sv;
    logic        raw;
    logic        neck_out, neck_busy;
    logic [15:0] event_cnt;
    logic        neck_out2, neck_busy2;
    logic [1:0]  event_cnt2;

    neck_signal_shaper #(
        .CONFIRM_N(CONFIRM_N), .PULSE_CYCLES(PULSE_C), .HOLDOFF_CYCLES(HOLD_C), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .en_shaper(en), .sample_valid(sv), .neck_raw(raw),
        .neck_out(neck_out), .neck_busy(neck_busy), .event_cnt(event_cnt)
    );

    neck_signal_shaper #(
        .CONFIRM_N(CONFIRM_N), .PULSE_CYCLES(PULSE_C), .HOLDOFF_CYCLES(HOLD_C), .CNT_W(2)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .en_shaper(en), .sample_valid(sv), .neck_raw(raw),
        .neck_out(neck_out2), .neck_busy(neck_busy2), .event_cnt(event_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an event is a timestamp k0; the pulse covers the P cycles starting
    // at k0, samples are blind until P+H edges later, after which a low sample re-arms.
    longint m_k;
    longint m_k0;
    int     m_streak;
    bit     m_act;
    int     m_cnt;
    bit     m_out;
    bit     m_busy;

    function automatic void model_edge(input bit r_i, input bit e_i, input bit s_i, input bit w_i);
        m_k++;
        if (r_i) begin
            m_streak = 0; m_act = 1'b0; m_cnt = 0;
        end else if (!e_i) begin
            m_streak = 0; m_act = 1'b0;
        end else if (!m_act) begin
            if (s_i) begin
                m_streak = w_i ? m_streak + 1 : 0;
                if (m_streak == CONFIRM_N) begin
                    m_act    = 1'b1;
                    m_k0     = m_k;
                    m_streak = 0;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end else if (m_k - m_k0 > PULSE_C + HOLD_C) begin
            if (s_i && !w_i) m_act = 1'b0;
        end
        m_out  = m_act && (m_k - m_k0 < PULSE_C);
        m_busy = m_act || (m_streak > 0);
    endfunction

    int rises;
    int highs;
    bit prev_out;

    task automatic tick();
        @(posedge clk);
        model_edge(rst, en, sv, raw);
        @(negedge clk);
        check("mdl_out",  neck_out,   m_out);
        check("mdl_busy", neck_busy,  m_busy);
        check("mdl_cnt",  event_cnt,  m_cnt);
        check("mdl_cnt2", event_cnt2, (m_cnt > 3) ? 3 : m_cnt);
        if (neck_out && !prev_out) rises++;
        if (neck_out) highs++;
        prev_out = neck_out;
    endtask

    // One strobe followed by 7 quiet cycles; outputs captured right after the strobe edge.
    task automatic strobe(input bit r, output bit o, output bit b, output logic [15:0] c);
        sv = 1'b1; raw = r;
        tick();
        o = neck_out; b = neck_busy; c = event_cnt;
        sv = 1'b0;
        repeat (7) tick();
    endtask

    typedef struct {
        bit raw;
        bit exp_out;
        bit exp_busy;
        int exp_cnt;
    } vec_t;

    vec_t        tbl[10];
    bit          o, b;
    logic [15:0] c;

    initial begin
        // Glitch reject, confirm, then hold-off blindness and re-arm on a low sample.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1};

        m_k = 0; m_k0 = 0; m_streak = 0; m_act = 0; m_cnt = 0; m_out = 0; m_busy = 0;
        rises = 0; highs = 0; prev_out = 0;
        rst = 1'b1; en = 1'b1; sv = 1'b0; raw = 1'b0;
        tick();
        tick();
        check("rst_out",  neck_out,   0);
        check("rst_busy", neck_busy,  0);
        check("rst_cnt",  event_cnt,  0);
        check("rst_cnt2", event_cnt2, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            strobe(tbl[i].raw, o, b, c);
            check($sformatf("tbl%0d_out", i),  o, tbl[i].exp_out);
            check($sformatf("tbl%0d_busy", i), b, tbl[i].exp_busy);
            check($sformatf("tbl%0d_cnt", i),  c, tbl[i].exp_cnt);
        end

        // Held level: 20 high strobes, one pulse of exactly 10 clk.
        rises = 0; highs = 0;
        for (int s = 0; s < 20; s++) begin
            sv = 1'b1; raw = 1'b1;
            tick();
            if (s == 2) begin
                check("held_rise", neck_out, 1);
                check("held_cnt",  event_cnt, 2);
            end
            sv = 1'b0;
            repeat (7) tick();
        end
        check("held_rises", rises, 1);
        check("held_width", highs, PULSE_C);
        check("held_busy",  neck_busy, 1);

        // Re-arm with one low strobe, then a second confirmed pulse.
        strobe(1'b0, o, b, c);
        check("rearm_busy", b, 0);
        rises = 0; highs = 0;
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        check("rearm_rise", o, 1);
        check("rearm_cnt",  c, 3);
        for (int s = 0; s < 5; s++) strobe(1'b0, o, b, c);
        check("rearm_rises", rises, 1);
        check("rearm_width", highs, PULSE_C);
        check("rearm_idle",  neck_busy, 0);

        // Abort on the 4th pulse cycle, then re-enable straight into a strobe.
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        sv = 1'b1; raw = 1'b1;
        tick();
        check("abort_rise", neck_out, 1);
        sv = 1'b0;
        repeat (3) tick();
        check("abort_pre", neck_out, 1);
        en = 1'b0;
        tick();
        check("abort_out",  neck_out,   0);
        check("abort_busy", neck_busy,  0);
        check("abort_cnt",  event_cnt,  4);
        check("sat_cnt4",   event_cnt2, 3);
        en = 1'b1;
        rises = 0; highs = 0;
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        check("reen_rise", o, 1);
        for (int s = 0; s < 5; s++) strobe(1'b0, o, b, c);
        check("reen_rises", rises, 1);
        check("reen_width", highs, PULSE_C);
        check("reen_cnt",   event_cnt, 5);
        check("sat_cnt5",   event_cnt2, 3);

        // Synchronous reset mid-pulse.
        strobe(1'b1, o, b, c);
        strobe(1'b1, o, b, c);
        sv = 1'b1; raw = 1'b1;
        tick();
        sv = 1'b0;
        repeat (2) tick();
        check("mid_pulse", neck_out, 1);
        rst = 1'b1;
        tick();
        check("rstp_out",  neck_out,   0);
        check("rstp_busy", neck_busy,  0);
        check("rstp_cnt",  event_cnt,  0);
        check("rstp_cnt2", event_cnt2, 0);
        rst = 1'b0; raw = 1'b0;
        tick();

        // Randomized traffic: mostly 8-clk strobes, sticky raw level, rare disable/reset.
        for (int cyc = 0; cyc < 6000; cyc++) begin
            sv  = ((cyc % 8) == 0) || ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) raw = ~raw;
            en  = ($urandom_range(0, 59) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
